// File: rtl/riscv_fetch_pkg.sv
// Shared fetch-stage constants and helpers, also used by decode.
package riscv_fetch_pkg;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;  // addi x0,x0,0

  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// In-order FIFO with synchronous clear; count holds 0..DEPTH inclusive.
module sync_fifo
  import riscv_fetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int CW = count_width(DEPTH),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify push/pop against full/empty and expose the head entry
  always_comb begin
    do_push_s = push && (count_r != CW'(DEPTH));
    do_pop_s  = pop && (count_r != {CW{1'b0}});
    pop_data  = mem_r[rd_ptr_r];
    count     = count_r;
  end

  // Storage, pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (clear) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_buffer.sv
// Fetch buffer: issues PC reads to instruction memory under a credit limit and
// pairs in-order responses with their addresses for decode.
module instr_fetch_buffer
  import riscv_fetch_pkg::*;
#(
  parameter int PC_WIDTH   = 16,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PC_WIDTH-1:0]   pc,
  output logic                  pc_advance,
  input  logic                  flush,
  output logic                  imem_req_valid,
  output logic [PC_WIDTH-1:0]   imem_req_addr,
  input  logic                  imem_req_ready,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]   instr_pc,
  input  logic                  instr_ready
);

  localparam int            CW           = count_width(DEPTH);
  localparam logic [CW:0]   CREDIT_LIMIT = (CW+1)'(DEPTH);

  logic [CW-1:0]         addr_count_s;
  logic [CW-1:0]         data_count_s;
  logic [CW-1:0]         live_s;
  logic [CW-1:0]         drop_cnt_r;
  logic [CW-1:0]         drop_nxt_s;
  logic [CW:0]           credit_use_s;
  logic                  fire_s;
  logic                  pop_s;
  logic                  rsp_keep_s;
  logic [PC_WIDTH-1:0]   addr_head_s;
  logic [DATA_WIDTH-1:0] data_head_s;

  // Credits count stale responses too, so the buffer can never overflow
  always_comb begin
    live_s         = addr_count_s - data_count_s;
    credit_use_s   = {1'b0, addr_count_s} + {1'b0, drop_cnt_r};
    imem_req_valid = rst && !flush && (credit_use_s < CREDIT_LIMIT);
    imem_req_addr  = pc;
    fire_s         = imem_req_valid && imem_req_ready;
    pc_advance     = fire_s;
    instr_valid    = (data_count_s != {CW{1'b0}});
    pop_s          = instr_valid && instr_ready && !flush;
    instr          = instr_valid ? data_head_s : DATA_WIDTH'(INSTR_NOP);
    instr_pc       = instr_valid ? addr_head_s : {PC_WIDTH{1'b0}};
  end

  // Response steering: stale ones are absorbed by drop_cnt, orphan ones ignored
  always_comb begin
    drop_nxt_s = drop_cnt_r;
    rsp_keep_s = 1'b0;
    if (flush) begin
      if (imem_rsp_valid && ((drop_cnt_r != {CW{1'b0}}) || (live_s != {CW{1'b0}}))) begin
        drop_nxt_s = drop_cnt_r + live_s - CW'(1'b1);
      end else begin
        drop_nxt_s = drop_cnt_r + live_s;
      end
    end else if (imem_rsp_valid) begin
      if (drop_cnt_r != {CW{1'b0}}) begin
        drop_nxt_s = drop_cnt_r - CW'(1'b1);
      end else begin
        rsp_keep_s = (live_s != {CW{1'b0}});
      end
    end else begin
      drop_nxt_s = drop_cnt_r;
    end
  end

  // Stale-response counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt_r <= {CW{1'b0}};
    end else begin
      drop_cnt_r <= drop_nxt_s;
    end
  end

  sync_fifo #(.WIDTH(PC_WIDTH), .DEPTH(DEPTH)) u_addr_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (fire_s),
    .push_data (pc),
    .pop       (pop_s),
    .pop_data  (addr_head_s),
    .count     (addr_count_s)
  );

  sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_data_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (rsp_keep_s),
    .push_data (imem_rsp_data),
    .pop       (pop_s),
    .pop_data  (data_head_s),
    .count     (data_count_s)
  );

endmodule

// File: doc/instr_fetch_buffer.md
# instr_fetch_buffer

Fetch stage directly downstream of the program counter. Takes the current PC and issues it as a read request to instruction memory, which has variable latency and returns responses in order. It pairs each returned word with its address in a small in-order buffer and hands {instr, instr_pc} to decode over a valid/ready handshake. A taken branch (flush) empties the buffer and silently drops all in-flight responses.

## Interface
- PC_WIDTH, 16, PC/address width
- DATA_WIDTH, 32, instruction width
- DEPTH, 4, buffer entries; power of two, ≥2
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- pc  in  PC_WIDTH  current PC from the program counter
- pc_advance  out  1  high in a cycle where pc was accepted by memory; PC steps next edge
- flush  in  1  branch taken (PCsrc); discard all fetched and in-flight instructions
- imem_req_valid  out  1  read request valid
- imem_req_addr  out  PC_WIDTH  read address (= pc)
- imem_req_ready  in  1  memory accepts request
- imem_rsp_valid  in  1  read data valid, in request order
- imem_rsp_data  in  DATA_WIDTH  read data
- instr_valid  out  1  buffer head valid
- instr  out  DATA_WIDTH  head instruction; INSTR_NOP when instr_valid=0
- instr_pc  out  PC_WIDTH  address of head instruction
- instr_ready  in  1  decode consumes head

## Operation
- Two in-order FIFOs of DEPTH entries:
  - addr FIFO: pushed with pc on request fire.
  - data FIFO: pushed with imem_rsp_data on a kept response.
  - Both popped together on instr_valid & instr_ready.
- live = addr_count − data_count, the outstanding non-dropped requests.
- drop_cnt: number of stale responses still to be discarded.
- Credit rule: imem_req_valid = !flush && (addr_count + drop_cnt < DEPTH). Fire = imem_req_valid & imem_req_ready. pc_advance = fire.
- instr_valid = (data_count ≠ 0). instr and instr_pc come from the FIFO heads.
- Response handling:
  - If drop_cnt > 0: discard the response; drop_cnt−1.
  - Else: push it to the data FIFO.
- Flush cycle:
  - Both FIFOs clear.
  - No request is issued.
  - Any pop is ignored.
  - drop_cnt ← drop_cnt + live − (imem_rsp_valid ? 1 : 0).
  - A response arriving in the flush cycle is discarded.
- Simultaneous push and pop on either FIFO is legal; the count is unchanged.
- A response while live = 0 and drop_cnt = 0 is a protocol violation: ignore it, and the bench asserts on it.
- Counts are $clog2(DEPTH)+1 bits wide. Pointers wrap modulo DEPTH.

## Timing
- Reset (rst low, asynchronous) clears:
  - both FIFOs and drop_cnt;
  - imem_req_valid=0, pc_advance=0, instr_valid=0, instr=INSTR_NOP, instr_pc=0.
- Reset has priority over every other input. Reset mid-transaction discards everything, and responses still returned by memory afterwards are protocol violations.
- imem_req_valid, imem_req_addr and pc_advance are combinational from pc, flush and the registered counts.
- The credit check uses current-cycle counts; a same-cycle pop does not free credit.
- Minimum latency with 1-cycle memory:
  - request in cycle N;
  - response in N+1;
  - instr_valid in N+2;
  - with instr_ready held high, the pop also happens in N+2.
- With DEPTH=4, 1-cycle memory and instr_ready held high, the block sustains one instruction per cycle. DEPTH=2 gives 2 per 3 cycles.
- The first request is allowed in the cycle after flush.

## Structure
- Package riscv_fetch_pkg holds:
  - localparam INSTR_NOP = 32'h0000_0013 (addi x0,x0,0);
  - the count-width function shared with decode.
- Sub-module sync_fifo #(WIDTH, DEPTH):
  - push, pop, clear, data in/out, count;
  - async active-low reset;
  - instantiated twice (addr FIFO, data FIFO).
- drop_cnt, the credit logic and the flush logic live in the top.

## Test plan
- 1-cycle memory, instr_ready=1, pc 0,4,8,…: instr_pc sequence 0,4,8 starting at cycle 2 with no gaps; pc_advance high every cycle.
- instr_ready=0 throughout: exactly 4 requests fire, then imem_req_valid=0 with data_count=4; one ready pulse frees one credit the following cycle.
- 3-cycle memory latency, flush with 2 requests live, new pc=0x40: the 2 stale responses are dropped; the first instr_valid has instr_pc=0x40.
- Flush in the same cycle as imem_rsp_valid, with live=1: the response is discarded, drop_cnt stays 0, and the buffer is empty next cycle.
- Assert rst low while live=2 and data_count=1: all outputs return to reset values immediately, without waiting for a clock edge.
- Randomised imem_req_ready and instr_ready against a scoreboard: instr equals the memory model word at instr_pc, in order, with no loss or duplication across random flushes.
